// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the branch/call/return sequencer: op codes and FSM states.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_JUMP   = 2'b01,
    OP_CALL   = 2'b10,
    OP_RETURN = 2'b11
  } op_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack: register array with occupancy count; the parent guards full/empty.
module ret_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; only occupancy matters after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[IW'(count)] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push) begin
      count <= count + CW'(1);
    end else if (pop) begin
      count <= count - CW'(1);
    end
  end

  assign top = mem[IW'(count - CW'(1))];

endmodule

// File: rtl/pc_branch_ctrl.sv
// Branch/call/return sequencer driving the pc redirect inputs, with a hardware
// return-address stack and trap redirect on stack overflow/underflow.
module pc_branch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned                INSTR_ADDR_SIZE = 5,
  parameter int unsigned                STACK_DEPTH     = 4,
  parameter logic [INSTR_ADDR_SIZE-1:0] TRAP_ADDR       = '1
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 OP_VALID,
  input  logic [1:0]                           OP,
  input  logic [INSTR_ADDR_SIZE-1:0]           TARGET,
  input  logic [INSTR_ADDR_SIZE-1:0]           PC_IN,
  input  logic                                 CLR_ERR,
  output logic                                 OP_READY,
  output logic                                 JMP,
  output logic [INSTR_ADDR_SIZE-1:0]           JMP_ADDR,
  output logic                                 RET,
  output logic [INSTR_ADDR_SIZE-1:0]           RET_ADDR,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     SP,
  output logic                                 OVERFLOW,
  output logic                                 UNDERFLOW
);

  localparam int unsigned AW = INSTR_ADDR_SIZE;
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  state_e state, state_next;
  logic   accept, full, empty;
  logic   push, pop, ovf_set, udf_set;

  assign OP_READY = (state == S_RUN) && !RST;
  assign accept   = OP_VALID && OP_READY;
  assign full     = (SP == CW'(STACK_DEPTH));
  assign empty    = (SP == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // A fault always costs exactly one bubble cycle before accepting again.
  always_comb begin
    state_next = S_RUN;
    if (state == S_RUN && (ovf_set || udf_set)) begin
      state_next = S_FAULT;
    end
  end

  // Redirect decode: combinational so pc redirects on the accepting edge.
  always_comb begin
    JMP      = 1'b0;
    RET      = 1'b0;
    JMP_ADDR = TARGET;
    push     = 1'b0;
    pop      = 1'b0;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    if (accept) begin
      unique case (op_e'(OP))
        OP_NOP: ;
        OP_JUMP: JMP = 1'b1;
        OP_CALL: begin
          JMP = 1'b1;
          if (full) begin
            JMP_ADDR = TRAP_ADDR;
            ovf_set  = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        OP_RETURN: begin
          if (empty) begin
            JMP      = 1'b1;
            JMP_ADDR = TRAP_ADDR;
            udf_set  = 1'b1;
          end else begin
            RET = 1'b1;
            pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky fault flags; a new fault beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (CLR_ERR) begin
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end
      if (ovf_set) OVERFLOW  <= 1'b1;
      if (udf_set) UNDERFLOW <= 1'b1;
    end
  end

  ret_addr_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (AW)
  ) u_stack (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .pop       (pop),
    .push_data (PC_IN + AW'(1)),
    .top       (RET_ADDR),
    .count     (SP)
  );

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl (A=5, DEPTH=4, TRAP=0x1F) with hand-computed expectations.
module tb_pc_branch_ctrl;

  localparam logic [1:0] NOP = 2'b00, JUMP = 2'b01, CALL = 2'b10, RTN = 2'b11;

  logic       CLK = 1'b0;
  logic       RST, OP_VALID, CLR_ERR;
  logic [1:0] OP;
  logic [4:0] TARGET, PC_IN;
  logic       OP_READY, JMP, RET, OVERFLOW, UNDERFLOW;
  logic [4:0] JMP_ADDR, RET_ADDR;
  logic [2:0] SP;

  int n_cmp = 0;
  int n_bad = 0;

  pc_branch_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .OP_VALID  (OP_VALID),
    .OP        (OP),
    .TARGET    (TARGET),
    .PC_IN     (PC_IN),
    .CLR_ERR   (CLR_ERR),
    .OP_READY  (OP_READY),
    .JMP       (JMP),
    .JMP_ADDR  (JMP_ADDR),
    .RET       (RET),
    .RET_ADDR  (RET_ADDR),
    .SP        (SP),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge and settle before sampling.
  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] tgt,
                       input logic [4:0] pc, input logic clr);
    OP_VALID = v; OP = op; TARGET = tgt; PC_IN = pc; CLR_ERR = clr;
    #1;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    drive(0, NOP, 5'h00, 5'h00, 0);
    tick(); tick();
    check("rst_ready", 32'(OP_READY), 0);
    check("rst_jmp", 32'(JMP), 0);
    check("rst_ret", 32'(RET), 0);
    check("rst_sp", 32'(SP), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_udf", 32'(UNDERFLOW), 0);
    RST = 1'b0;
    #1;
    check("rel_ready", 32'(OP_READY), 1);

    // NOP and JUMP
    drive(1, NOP, 5'h0C, 5'h01, 0);
    check("nop_jmp", 32'(JMP), 0);
    check("nop_ret", 32'(RET), 0);
    tick();
    drive(1, JUMP, 5'h15, 5'h02, 0);
    check("jump_jmp", 32'(JMP), 1);
    check("jump_addr", 32'(JMP_ADDR), 32'h15);
    tick();
    drive(0, NOP, 5'h00, 5'h15, 0);
    check("jump_sp", 32'(SP), 0);

    // Call / return
    drive(1, CALL, 5'h0A, 5'h03, 0);
    check("call_jmp", 32'(JMP), 1);
    check("call_addr", 32'(JMP_ADDR), 32'h0A);
    check("call_ret", 32'(RET), 0);
    tick();
    drive(0, NOP, 5'h00, 5'h0A, 0);
    check("call_sp", 32'(SP), 1);
    check("call_top", 32'(RET_ADDR), 32'h04);
    drive(1, RTN, 5'h00, 5'h0B, 0);
    check("ret_ret", 32'(RET), 1);
    check("ret_jmp", 32'(JMP), 0);
    check("ret_addr", 32'(RET_ADDR), 32'h04);
    tick();
    drive(0, NOP, 5'h00, 5'h04, 0);
    check("ret_sp", 32'(SP), 0);

    // Overflow: four nested calls from pc 1..4 push 2..5
    for (int i = 1; i <= 4; i++) begin
      drive(1, CALL, 5'h10, 5'(i), 0);
      tick();
    end
    drive(0, NOP, 5'h00, 5'h10, 0);
    check("full_sp", 32'(SP), 4);
    check("full_top", 32'(RET_ADDR), 32'h05);
    drive(1, CALL, 5'h08, 5'h10, 0);
    check("ovf_ready", 32'(OP_READY), 1);
    check("ovf_jmp", 32'(JMP), 1);
    check("ovf_addr", 32'(JMP_ADDR), 32'h1F);
    tick();
    drive(1, CALL, 5'h08, 5'h1F, 0);
    check("fault_ready", 32'(OP_READY), 0);
    check("fault_jmp", 32'(JMP), 0);
    check("fault_ret", 32'(RET), 0);
    check("ovf_flag", 32'(OVERFLOW), 1);
    check("ovf_sp", 32'(SP), 4);
    tick();
    drive(0, NOP, 5'h00, 5'h1F, 0);
    check("post_fault_ready", 32'(OP_READY), 1);
    check("post_fault_sp", 32'(SP), 4);
    for (int i = 5; i >= 2; i--) begin
      drive(1, RTN, 5'h00, 5'h1F, 0);
      check($sformatf("drain_ret%0d", i), 32'(RET), 1);
      check($sformatf("drain_addr%0d", i), 32'(RET_ADDR), 32'(i));
      tick();
    end
    drive(0, NOP, 5'h00, 5'h02, 1);
    check("drain_sp", 32'(SP), 0);
    check("ovf_before_clr", 32'(OVERFLOW), 1);
    tick();
    drive(0, NOP, 5'h00, 5'h02, 0);
    check("ovf_cleared", 32'(OVERFLOW), 0);

    // Underflow and clear semantics
    drive(1, RTN, 5'h00, 5'h06, 0);
    check("udf_ret", 32'(RET), 0);
    check("udf_jmp", 32'(JMP), 1);
    check("udf_addr", 32'(JMP_ADDR), 32'h1F);
    tick();
    drive(0, NOP, 5'h00, 5'h1F, 0);
    check("udf_flag", 32'(UNDERFLOW), 1);
    check("udf_ready", 32'(OP_READY), 0);
    tick();
    drive(0, NOP, 5'h00, 5'h00, 1);
    tick();
    drive(0, NOP, 5'h00, 5'h00, 0);
    check("udf_cleared", 32'(UNDERFLOW), 0);
    drive(1, RTN, 5'h00, 5'h07, 1);
    tick();
    drive(0, NOP, 5'h00, 5'h1F, 0);
    check("set_beats_clr", 32'(UNDERFLOW), 1);
    tick();
    drive(0, NOP, 5'h00, 5'h00, 1);
    tick();

    // Wrap and back-to-back call/return
    drive(1, CALL, 5'h07, 5'h1F, 0);
    check("wrap_addr", 32'(JMP_ADDR), 32'h07);
    tick();
    drive(0, NOP, 5'h00, 5'h07, 0);
    check("wrap_top", 32'(RET_ADDR), 32'h00);
    check("wrap_sp", 32'(SP), 1);
    drive(1, CALL, 5'h12, 5'h10, 0);
    tick();
    drive(1, RTN, 5'h00, 5'h12, 0);
    check("b2b_ret1", 32'(RET), 1);
    check("b2b_addr1", 32'(RET_ADDR), 32'h11);
    tick();
    drive(1, RTN, 5'h00, 5'h11, 0);
    check("b2b_ret2", 32'(RET), 1);
    check("b2b_addr2", 32'(RET_ADDR), 32'h00);
    tick();
    drive(0, NOP, 5'h00, 5'h00, 0);
    check("b2b_sp", 32'(SP), 0);

    // Reset asserted during the fault bubble
    for (int i = 0; i < 5; i++) begin
      drive(1, CALL, 5'h09, 5'h08, 0);
      tick();
    end
    drive(0, NOP, 5'h00, 5'h1F, 0);
    check("mid_state_fault", 32'(OP_READY), 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("mid_ready", 32'(OP_READY), 1);
    check("mid_sp", 32'(SP), 0);
    check("mid_ovf", 32'(OVERFLOW), 0);
    check("mid_udf", 32'(UNDERFLOW), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
